// File: rtl/exe_stage_if.sv
// rtl/exe_stage_if.sv - valid/allowin/bus handshake between pipeline stages
// The producer drives valid and bus; the consumer answers with allowin.
interface exe_stage_if #(
   parameter int W = 1
);
   logic         valid;
   logic         allowin;
   logic [W-1:0] bus;

   modport master (output valid, output bus, input allowin);
   modport slave  (input valid, input bus, output allowin);
endinterface

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: ALU, data SRAM request, iterative divider
// Holds one instruction; a divide keeps the stage occupied for 33 cycles.
module exe_stage #(
   parameter int DS2ES_LEN = 143,
   parameter int ES2MS_LEN = 71
) (
   input  logic        clk,
   input  logic        reset,
   exe_stage_if.slave  ds2es,
   exe_stage_if.master es2ms,
   output logic        data_sram_en,
   output logic [3:0]  data_sram_we,
   output logic [31:0] data_sram_addr,
   output logic [31:0] data_sram_wdata,
   output logic        exe_rf_we,
   output logic [4:0]  exe_dest,
   output logic        exe_res_from_mem,
   output logic [31:0] exe_result
);

   logic [DS2ES_LEN-1:0] ds_bus;
   logic [ES2MS_LEN-1:0] ms_bus;

   logic [31:0] in_pc, in_src1, in_src2, in_st_data;
   logic [3:0]  in_alu_op;
   logic [2:0]  in_div_op;
   logic        in_mem_we, in_res_from_mem, in_gr_we;
   logic [4:0]  in_dest;

   logic        es_valid_q;
   logic [31:0] pc_q, src1_q, src2_q, st_data_q;
   logic [3:0]  alu_op_q;
   logic [2:0]  div_op_q;
   logic        mem_we_q, res_from_mem_q, gr_we_q;
   logic [4:0]  dest_q;

   logic [5:0]  div_cnt_q;
   logic        div_done_q;
   logic [31:0] div_rem_q, div_quo_q;
   logic [31:0] div_rem_d, div_quo_d;

   logic        es_ready_go, es_allowin, es2ms_valid, handoff, div_busy;
   logic [31:0] alu_result, div_result, result;

   assign ds_bus = ds2es.bus;
   assign {in_pc, in_src1, in_src2, in_st_data, in_alu_op, in_div_op,
           in_mem_we, in_res_from_mem, in_dest, in_gr_we} = ds_bus;

   assign es_ready_go = ~div_op_q[2] | div_done_q;
   assign es_allowin  = ~es_valid_q | (es_ready_go & es2ms.allowin);
   assign es2ms_valid = es_valid_q & es_ready_go;
   assign handoff     = es2ms_valid & es2ms.allowin;
   assign div_busy    = es_valid_q & div_op_q[2] & ~div_done_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         es_valid_q <= 1'b0;
      end else if (es_allowin) begin
         es_valid_q <= ds2es.valid;
      end
   end

   always_ff @(posedge clk) begin
      if (ds2es.valid & es_allowin) begin
         pc_q           <= in_pc;
         src1_q         <= in_src1;
         src2_q         <= in_src2;
         st_data_q      <= in_st_data;
         alu_op_q       <= in_alu_op;
         div_op_q       <= in_div_op;
         mem_we_q       <= in_mem_we;
         res_from_mem_q <= in_res_from_mem;
         dest_q         <= in_dest;
         gr_we_q        <= in_gr_we;
      end
   end

   always_comb begin
      alu_result = 32'd0;
      case (alu_op_q)
         4'd0:    alu_result = src1_q + src2_q;
         4'd1:    alu_result = src1_q - src2_q;
         4'd2:    alu_result = {31'd0, $signed(src1_q) < $signed(src2_q)};
         4'd3:    alu_result = {31'd0, src1_q < src2_q};
         4'd4:    alu_result = src1_q & src2_q;
         4'd5:    alu_result = src1_q | src2_q;
         4'd6:    alu_result = src1_q ^ src2_q;
         4'd7:    alu_result = ~(src1_q | src2_q);
         4'd8:    alu_result = src1_q << src2_q[4:0];
         4'd9:    alu_result = src1_q >> src2_q[4:0];
         4'd10:   alu_result = $unsigned($signed(src1_q) >>> src2_q[4:0]);
         4'd11:   alu_result = src2_q;
         default: alu_result = 32'd0;
      endcase
   end

   logic        a_neg, b_neg;
   logic [31:0] abs_a, abs_b, cur_rem, cur_dvd, diff, quo_fix, rem_fix;
   logic [32:0] shifted;
   logic        q_bit;

   assign a_neg = div_op_q[1] & src1_q[31];
   assign b_neg = div_op_q[1] & src2_q[31];
   assign abs_a = a_neg ? (~src1_q + 32'd1) : src1_q;
   assign abs_b = b_neg ? (~src2_q + 32'd1) : src2_q;

   // Iteration 0 works straight from the latched operands so that 32
   // iterations fit in cycles 0..31 and the result is ready in cycle 32.
   always_comb begin
      cur_rem   = (div_cnt_q == 6'd0) ? 32'd0 : div_rem_q;
      cur_dvd   = (div_cnt_q == 6'd0) ? abs_a : div_quo_q;
      shifted   = {cur_rem, cur_dvd[31]};
      q_bit     = (shifted >= {1'b0, abs_b});
      diff      = shifted[31:0] - abs_b;
      div_rem_d = q_bit ? diff : shifted[31:0];
      div_quo_d = {cur_dvd[30:0], q_bit};
   end

   always_ff @(posedge clk) begin
      if (reset || handoff) begin
         div_cnt_q  <= 6'd0;
         div_done_q <= 1'b0;
      end else if (div_busy) begin
         div_cnt_q <= div_cnt_q + 6'd1;
         div_rem_q <= div_rem_d;
         div_quo_q <= div_quo_d;
         if (div_cnt_q == 6'd31) begin
            div_done_q <= 1'b1;
         end
      end
   end

   // A zero divisor leaves all-ones quotient and the raw dividend as remainder.
   always_comb begin
      if (src2_q == 32'd0) begin
         quo_fix = 32'hFFFF_FFFF;
         rem_fix = src1_q;
      end else begin
         quo_fix = (a_neg ^ b_neg) ? (~div_quo_q + 32'd1) : div_quo_q;
         rem_fix = a_neg ? (~div_rem_q + 32'd1) : div_rem_q;
      end
   end

   assign div_result = div_op_q[0] ? rem_fix : quo_fix;
   assign result     = div_op_q[2] ? div_result : alu_result;

   assign ds2es.allowin = es_allowin;
   assign es2ms.valid   = es2ms_valid;
   assign ms_bus        = {pc_q, result, res_from_mem_q, dest_q, gr_we_q};
   assign es2ms.bus     = ms_bus;

   assign data_sram_en    = es_valid_q & (res_from_mem_q | mem_we_q) & es2ms.allowin;
   assign data_sram_we    = {4{es_valid_q & mem_we_q & es2ms.allowin}};
   assign data_sram_addr  = alu_result;
   assign data_sram_wdata = st_data_q;

   assign exe_rf_we        = es_valid_q & gr_we_q;
   assign exe_dest         = dest_q;
   assign exe_res_from_mem = es_valid_q & res_from_mem_q;
   assign exe_result       = result;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed bench for exe_stage with a cycle-level occupancy model
module tb_exe_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        data_sram_en;
   logic [3:0]  data_sram_we;
   logic [31:0] data_sram_addr, data_sram_wdata, exe_result;
   logic        exe_rf_we, exe_res_from_mem;
   logic [4:0]  exe_dest;

   exe_stage_if #(.W(143)) ds2es ();
   exe_stage_if #(.W(71))  es2ms ();

   exe_stage #(.DS2ES_LEN(143), .ES2MS_LEN(71)) dut (
      .clk(clk), .reset(reset), .ds2es(ds2es), .es2ms(es2ms),
      .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .exe_rf_we(exe_rf_we), .exe_dest(exe_dest),
      .exe_res_from_mem(exe_res_from_mem), .exe_result(exe_result)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no response within cycle budget at %0t", name, $time);
   endtask

   function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] aop, input logic [2:0] dop);
      logic [31:0] q, r;
      if (dop[2]) begin
         if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
         end else if (dop[1]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               q = a; r = 32'd0;
            end else begin
               q = $signed(a) / $signed(b);
               r = $signed(a) % $signed(b);
            end
         end else begin
            q = a / b; r = a % b;
         end
         return dop[0] ? r : q;
      end
      case (aop)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd3:    return (a < b) ? 32'd1 : 32'd0;
         4'd4:    return a & b;
         4'd5:    return a | b;
         4'd6:    return a ^ b;
         4'd7:    return ~(a | b);
         4'd8:    return a << b[4:0];
         4'd9:    return a >> b[4:0];
         4'd10:   return $unsigned($signed(a) >>> b[4:0]);
         4'd11:   return b;
         default: return 32'd0;
      endcase
   endfunction

   // Model: is an instruction resident, and how many cycles until it may leave.
   bit          armed = 0;
   bit          m_occ = 0;
   int          m_wait = 0;
   logic [31:0] m_pc, m_s1, m_s2, m_sd;
   logic [3:0]  m_aop;
   logic [2:0]  m_dop;
   logic        m_mw, m_rfm, m_gw;
   logic [4:0]  m_dst;

   always @(posedge clk) begin
      bit pop, allow;
      if (reset) begin
         armed = 1;
         m_occ = 0;
      end else begin
         pop   = m_occ && (m_wait == 0) && es2ms.allowin;
         allow = !m_occ || pop;
         if (m_occ && m_wait != 0) m_wait--;
         if (pop) m_occ = 0;
         if (ds2es.valid && allow) begin
            {m_pc, m_s1, m_s2, m_sd, m_aop, m_dop, m_mw, m_rfm, m_dst, m_gw} = ds2es.bus;
            m_occ  = 1;
            m_wait = m_dop[2] ? 32 : 0;
         end
      end
   end

   always @(negedge clk) begin
      bit exp_v, ms;
      if (armed) begin
         ms    = es2ms.allowin;
         exp_v = m_occ && (m_wait == 0);
         chk("es2ms_valid", 71'(es2ms.valid), 71'(exp_v));
         chk("es_allowin", 71'(ds2es.allowin), 71'(!m_occ || (exp_v && ms)));
         chk("sram_en", 71'(data_sram_en), 71'(m_occ && (m_rfm || m_mw) && ms));
         chk("sram_we", 71'(data_sram_we), 71'({4{m_occ && m_mw && ms}}));
         chk("exe_rf_we", 71'(exe_rf_we), 71'(m_occ && m_gw));
         chk("exe_res_from_mem", 71'(exe_res_from_mem), 71'(m_occ && m_rfm));
         if (m_occ) chk("exe_dest", 71'(exe_dest), 71'(m_dst));
         if (m_occ && (m_rfm || m_mw) && ms) begin
            chk("sram_addr", 71'(data_sram_addr), 71'(m_s1 + m_s2));
            chk("sram_wdata", 71'(data_sram_wdata), 71'(m_sd));
         end
         if (exp_v) begin
            chk("es2ms_bus", es2ms.bus,
                {m_pc, model_res(m_s1, m_s2, m_aop, m_dop), m_rfm, m_dst, m_gw});
            chk("exe_result", 71'(exe_result), 71'(model_res(m_s1, m_s2, m_aop, m_dop)));
         end
      end
   end

   logic [31:0] pc_ctr = 32'h1C00_0000;

   task automatic send(input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] sd,
                       input logic [3:0] aop, input logic [2:0] dop, input logic mw,
                       input logic rfm, input logic [4:0] dst, input logic gw);
      bit ok = 0;
      @(posedge clk); #1;
      ds2es.valid = 1'b1;
      ds2es.bus   = {pc_ctr, s1, s2, sd, aop, dop, mw, rfm, dst, gw};
      pc_ctr      = pc_ctr + 32'd4;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = ds2es.allowin;
         @(posedge clk);
      end
      #1 ds2es.valid = 1'b0;
      if (!ok) timeout("send_accept");
   endtask

   // Returns with time at the negedge of the first cycle es2ms_valid is high.
   task automatic wait_out(output int lat, output int allow_seen);
      lat = -1;
      allow_seen = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (es2ms.valid) begin
            lat = c + 1;
            return;
         end
         if (ds2es.allowin) allow_seen++;
         @(posedge clk);
      end
      timeout("wait_es2ms_valid");
   endtask

   typedef struct packed { logic [3:0] op; logic [31:0] exp; } alu_vec_t;
   typedef struct packed { logic [2:0] dop; logic [31:0] a; logic [31:0] b; logic [31:0] exp; } div_vec_t;

   alu_vec_t alu_tab [14] = '{
      '{4'd0, 32'h8000_00F4}, '{4'd1, 32'h8000_00EC}, '{4'd2, 32'h0000_0001},
      '{4'd3, 32'h0000_0000}, '{4'd4, 32'h0000_0000}, '{4'd5, 32'h8000_00F4},
      '{4'd6, 32'h8000_00F4}, '{4'd7, 32'h7FFF_FF0B}, '{4'd8, 32'h0000_0F00},
      '{4'd9, 32'h0800_000F}, '{4'd10, 32'hF800_000F}, '{4'd11, 32'h0000_0004},
      '{4'd13, 32'h0000_0000}, '{4'd15, 32'h0000_0000}};

   div_vec_t div_tab [10] = '{
      '{3'b100, 32'd100, 32'd7, 32'd14},
      '{3'b101, 32'd100, 32'd7, 32'd2},
      '{3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD},
      '{3'b111, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF},
      '{3'b110, 32'd9, 32'd0, 32'hFFFF_FFFF},
      '{3'b111, 32'd9, 32'd0, 32'd9},
      '{3'b100, 32'd9, 32'd0, 32'hFFFF_FFFF},
      '{3'b101, 32'd9, 32'd0, 32'd9},
      '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
      '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0}};

   initial begin
      int lat, allow_seen, stall_w, we_cnt;
      reset         = 1'b1;
      ds2es.valid   = 1'b0;
      ds2es.bus     = '0;
      es2ms.allowin = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_valid", 71'(es2ms.valid), 71'(0));
      chk("reset_allowin", 71'(ds2es.allowin), 71'(1));
      chk("reset_sram_we", 71'(data_sram_we), 71'(0));
      chk("reset_rf_we", 71'(exe_rf_we), 71'(0));
      @(posedge clk); #1 reset = 1'b0;

      send(32'd5, 32'd7, 32'd0, 4'd0, 3'b000, 1'b0, 1'b0, 5'd3, 1'b1);
      wait_out(lat, allow_seen);
      chk("add_latency", 71'(lat), 71'(1));
      chk("add_result", 71'(es2ms.bus[38:7]), 71'(12));
      chk("add_rf_we", 71'(exe_rf_we), 71'(1));
      chk("add_dest", 71'(exe_dest), 71'(3));

      foreach (alu_tab[i]) begin
         send(32'h8000_00F0, 32'h0000_0004, 32'd0, alu_tab[i].op, 3'b000, 1'b0, 1'b0, 5'd7, 1'b1);
         wait_out(lat, allow_seen);
         chk($sformatf("alu_op%0d", alu_tab[i].op), 71'(exe_result), 71'(alu_tab[i].exp));
      end

      // Store held by memory stage for 3 cycles: exactly one write when it leaves.
      @(posedge clk); #1 es2ms.allowin = 1'b0;
      send(32'h0000_1000, 32'd4, 32'hDEAD_BEEF, 4'd0, 3'b000, 1'b1, 1'b0, 5'd0, 1'b0);
      stall_w = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (data_sram_we != 4'h0) stall_w++;
         @(posedge clk);
      end
      #1 es2ms.allowin = 1'b1;
      we_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (data_sram_we == 4'hF) begin
            we_cnt++;
            chk("store_addr", 71'(data_sram_addr), 71'(32'h0000_1004));
            chk("store_wdata", 71'(data_sram_wdata), 71'(32'hDEAD_BEEF));
         end
         @(posedge clk);
      end
      chk("store_we_during_stall", 71'(stall_w), 71'(0));
      chk("store_we_pulses", 71'(we_cnt), 71'(1));

      foreach (div_tab[i]) begin
         send(div_tab[i].a, div_tab[i].b, 32'd0, 4'd0, div_tab[i].dop, 1'b0, 1'b0, 5'd9, 1'b1);
         wait_out(lat, allow_seen);
         chk($sformatf("div%0d_latency", i), 71'(lat), 71'(33));
         chk($sformatf("div%0d_allowin_busy", i), 71'(allow_seen), 71'(0));
         chk($sformatf("div%0d_result", i), 71'(es2ms.bus[38:7]), 71'(div_tab[i].exp));
      end

      // Divide finishing into a stalled memory stage, then a full-length follower.
      @(posedge clk); #1 es2ms.allowin = 1'b0;
      send(32'd100, 32'd7, 32'd0, 4'd0, 3'b100, 1'b0, 1'b0, 5'd4, 1'b1);
      wait_out(lat, allow_seen);
      chk("stall_div_latency", 71'(lat), 71'(33));
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("stall_div_valid", 71'(es2ms.valid), 71'(1));
         chk("stall_div_result", 71'(exe_result), 71'(14));
      end
      @(posedge clk); #1 es2ms.allowin = 1'b1;
      send(32'd100, 32'd7, 32'd0, 4'd0, 3'b101, 1'b0, 1'b0, 5'd5, 1'b1);
      wait_out(lat, allow_seen);
      chk("follow_div_latency", 71'(lat), 71'(33));
      chk("follow_div_result", 71'(exe_result), 71'(2));

      // Reset in the middle of a divide discards it.
      send(32'd1000, 32'd3, 32'd0, 4'd0, 3'b100, 1'b0, 1'b0, 5'd6, 1'b1);
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_valid", 71'(es2ms.valid), 71'(0));
      chk("abort_allowin", 71'(ds2es.allowin), 71'(1));
      send(32'd20, 32'd22, 32'd0, 4'd0, 3'b000, 1'b0, 1'b0, 5'd8, 1'b1);
      wait_out(lat, allow_seen);
      chk("after_abort_latency", 71'(lat), 71'(1));
      chk("after_abort_result", 71'(exe_result), 71'(42));

      @(posedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage in-order pipeline. Sits between the decode stage and the memory stage.
- Accepts one instruction per handshake from decode over ds2es_bus.
- Computes the ALU result and issues the data SRAM request for loads and stores.
- Runs an iterative 32-bit divider, holding the pipeline until the divide completes.
- Forwards results to the memory stage over es2ms_bus, and exports dest/result signals for bypass and load-use detection in decode.

Parameters:
DS2ES_LEN, 143, width of ds2es_bus
ES2MS_LEN, 71, width of es2ms_bus

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ds2es_valid  in  1  decode holds a valid instruction
es_allowin  out  1  this stage can accept an instruction this cycle
ds2es_bus  in  143  {pc[31:0], src1[31:0], src2[31:0], st_data[31:0], alu_op[3:0], div_op[2:0], mem_we, res_from_mem, dest[4:0], gr_we} (MSB first)
ms_allowin  in  1  memory stage can accept
es2ms_valid  out  1  valid instruction offered to memory stage
es2ms_bus  out  71  {pc[31:0], result[31:0], res_from_mem, dest[4:0], gr_we} (MSB first)
data_sram_en  out  1  data SRAM enable
data_sram_we  out  4  byte write enables
data_sram_addr  out  32  byte address
data_sram_wdata  out  32  store data
exe_rf_we  out  1  es_valid & gr_we (bypass)
exe_dest  out  5  destination register (bypass)
exe_res_from_mem  out  1  es_valid & res_from_mem (load-use stall)
exe_result  out  32  result being computed (bypass)

Behaviour:
- Reset:
  - es_valid=0; divider idle, div_cnt=0, div_done=0.
  - Therefore es2ms_valid, exe_rf_we, exe_res_from_mem, data_sram_en and data_sram_we all read 0.
  - Payload registers are don't-care.
- Handshake:
  - es_allowin = ~es_valid | (es_ready_go & ms_allowin).
  - es2ms_valid = es_valid & es_ready_go.
  - es_valid <= ds2es_valid when es_allowin.
  - Payload registers load only when ds2es_valid & es_allowin.
- es_ready_go = ~div_op[2] | div_done.
- ALU, combinational on the latched operands:
  - alu_op 0 add, 1 sub, 2 slt (signed), 3 sltu.
  - alu_op 4 and, 5 or, 6 xor, 7 nor.
  - alu_op 8 sll, 9 srl, 10 sra: shift amount is src2[4:0].
  - alu_op 11 pass src2.
  - alu_op 12-15 give 0.
- result = div_op[2] ? div_result : alu_result.
  - For loads and stores, alu_result (src1+src2) is the address.
- Data SRAM:
  - data_sram_en = es_valid & (res_from_mem | mem_we) & ms_allowin.
  - data_sram_we = {4{es_valid & mem_we & ms_allowin}}.
  - data_sram_addr = alu_result; data_sram_wdata = st_data.
  - A store writes exactly once: in the cycle the instruction leaves the stage.
- div_op encoding: [2] is a divide, [1] signed, [0] 0 = quotient, 1 = remainder.
- Divider, restoring radix-2, one quotient bit per cycle:
  - Idle: cnt=0, done=0. A divide instruction is latched into the stage.
  - Busy: each cycle is one iteration, cnt increments. Operands are absolute values when signed.
  - After 32 iterations: done=1, so a divide occupies the stage for exactly 33 cycles when ms_allowin=1.
  - done stays 1 while ms_allowin=0, and the result is held stable.
  - On handoff (es2ms_valid & ms_allowin): return to idle. A back-to-back divide restarts cleanly.
- Sign fix-up: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
- Corner cases:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend, in both signed and unsigned modes.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - Both corner cases still take 33 cycles.
- Reset during a divide aborts it. The instruction is discarded and no es2ms_valid is produced.
- es2ms_bus: result is taken from the latched instruction; fields are in the listed order.

Test Plan:
- add src1=5, src2=7, gr_we=1, dest=3, ms_allowin=1 -> one cycle later es2ms_valid=1, result=12, exe_rf_we=1, exe_dest=3.
- Store: src1=0x1000, src2=4, st_data=0xDEADBEEF, mem_we=1, with ms_allowin held 0 for 3 cycles then 1:
  - data_sram_we=0 during the stall.
  - data_sram_we=4'hF for exactly 1 cycle, addr=0x1004, wdata=0xDEADBEEF.
- Unsigned divide 100/7:
  - quotient op gives result 14; remainder op gives result 2.
  - es2ms_valid rises exactly 33 cycles after entry; es_allowin=0 throughout.
- Signed divide -7/2:
  - quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
  - Divide by zero of 9 gives quotient 0xFFFFFFFF and remainder 9.
  - 0x80000000/-1 gives quotient 0x80000000.
- Divide completes with ms_allowin=0 for 5 cycles -> es2ms_valid=1 and result stable throughout; hands off when ms_allowin=1.
  - A following divide then takes a full 33 cycles.
- Assert reset at divide cycle 10 -> es2ms_valid=0 and es_allowin=1 next cycle.
  - The next add completes in 1 cycle with the correct result.
